// File: rtl/inst_fetch_buffer_pkg.sv
// inst_fetch_buffer_pkg: shared bus widths, control constants,
// fetch FSM encodings and the {pc, inst} FIFO entry layout.
package inst_fetch_buffer_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;
   localparam int EntryW      = InstAddrBus + InstBus;

   localparam logic        RstEnable  = 1'b1;
   localparam logic        ChipEnable = 1'b1;
   localparam logic [31:0] ZeroWord   = 32'h0;

   typedef enum logic [1:0] {
      FetchIdle = 2'b00,
      FetchWait = 2'b01,
      FetchDrop = 2'b10
   } fetch_state_e;

   typedef struct packed {
      logic [InstAddrBus-1:0] pc;
      logic [InstBus-1:0]     inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular FIFO holding fetched {pc, inst} entries.
// Ports: clk/rst (async high), push/pop/clear, din, full/empty/count, head
// (head reads zero while empty).
module fetch_fifo
   import inst_fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count,
   output logic [WIDTH-1:0] head
);

   localparam logic [PTR_W:0] FullCnt = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign empty = (r_count == '0);
   assign full  = (r_count == FullCnt);
   assign count = r_count;
   assign head  = empty ? '0 : r_mem[r_rd_ptr];

   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !clear)
         r_mem[r_wr_ptr] <= din;
   end

endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: one-outstanding-request fetch engine with a {pc, inst}
// FIFO toward decode.
// Ports: clk/rst (async high); pc_i/ce_i/flush_i from PC stage;
// rom_req_o/rom_addr_o/rom_ack_i/rom_data_i to memory;
// id_valid_o/id_pc_o/id_inst_o/id_ready_i to decode; stall_req_o to PC stage.
module inst_fetch_buffer
   import inst_fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [InstAddrBus-1:0] pc_i,
   input  logic                   ce_i,
   input  logic                   flush_i,
   output logic                   rom_req_o,
   output logic [InstAddrBus-1:0] rom_addr_o,
   input  logic                   rom_ack_i,
   input  logic [InstBus-1:0]     rom_data_i,
   output logic                   id_valid_o,
   output logic [InstAddrBus-1:0] id_pc_o,
   output logic [InstBus-1:0]     id_inst_o,
   input  logic                   id_ready_i,
   output logic                   stall_req_o
);

   localparam logic [PTR_W:0] FullCnt = (PTR_W+1)'(DEPTH);

   fetch_state_e           r_state;
   fetch_state_e           w_state_nxt;
   logic                   r_req;
   logic                   w_req_nxt;
   logic [InstAddrBus-1:0] r_addr;
   logic [InstAddrBus-1:0] w_addr_nxt;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic [PTR_W:0]         w_count;
   fetch_entry_t           w_din;
   fetch_entry_t           w_head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         r_state <= FetchIdle;
         r_req   <= 1'b0;
         r_addr  <= ZeroWord;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   // An ack in WAIT under flush, or any ack in DROP, is swallowed:
   // the request could not be withdrawn, so its reply must be absorbed.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_addr_nxt  = r_addr;
      w_push      = 1'b0;
      unique case (r_state)
         FetchIdle: begin
            if (ce_i == ChipEnable && !flush_i && w_count < FullCnt) begin
               w_state_nxt = FetchWait;
               w_req_nxt   = 1'b1;
               w_addr_nxt  = pc_i;
            end else begin
               w_req_nxt = 1'b0;
            end
         end
         FetchWait: begin
            if (rom_ack_i) begin
               w_push      = !flush_i;
               w_req_nxt   = 1'b0;
               w_state_nxt = FetchIdle;
            end else if (flush_i) begin
               w_state_nxt = FetchDrop;
            end
         end
         FetchDrop: begin
            if (rom_ack_i) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = FetchIdle;
            end
         end
         default: begin
            w_state_nxt = FetchIdle;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

   assign w_din.pc   = r_addr;
   assign w_din.inst = rom_data_i;
   assign w_pop      = !w_empty && id_ready_i;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .WIDTH (EntryW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .clear (flush_i),
      .din   (w_din),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count),
      .head  (w_head)
   );

   assign rom_req_o   = r_req;
   assign rom_addr_o  = r_addr;
   assign id_valid_o  = !w_empty;
   assign id_pc_o     = w_head.pc;
   assign id_inst_o   = w_head.inst;
   assign stall_req_o = (r_state != FetchIdle) || w_full || flush_i;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: scenario tasks plus randomized traffic, checked
// every cycle against a queue-based transaction model of the fetch buffer.
module tb_inst_fetch_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_i = '0;
   logic        ce_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        rom_req_o;
   logic [31:0] rom_addr_o;
   logic        rom_ack_i = 1'b0;
   logic [31:0] rom_data_i = '0;
   logic        id_valid_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_ready_i = 1'b0;
   logic        stall_req_o;

   always #5 clk = ~clk;

   inst_fetch_buffer #(
      .DEPTH (DEPTH),
      .PTR_W (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_i        (pc_i),
      .ce_i        (ce_i),
      .flush_i     (flush_i),
      .rom_req_o   (rom_req_o),
      .rom_addr_o  (rom_addr_o),
      .rom_ack_i   (rom_ack_i),
      .rom_data_i  (rom_data_i),
      .id_valid_o  (id_valid_o),
      .id_pc_o     (id_pc_o),
      .id_inst_o   (id_inst_o),
      .id_ready_i  (id_ready_i),
      .stall_req_o (stall_req_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Transaction model: queue of {pc, inst}, plus the one outstanding fetch.
   logic [63:0] m_q[$];
   bit          m_busy = 0;
   bit          m_drop = 0;
   logic [31:0] m_addr = '0;
   int          m_wait = 0;

   int          lat_max = 0;
   bit          ack_en = 1;
   bit          stray = 0;
   bit          auto_pc = 0;
   bit          use_ovr = 0;
   bit          seen_dead = 0;
   logic [31:0] data_ovr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic step();
      logic        e_stall;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      bit          pop;
      bit          push;
      rom_ack_i  = m_busy ? (ack_en && m_wait == 0) : stray;
      rom_data_i = (m_busy && use_ovr) ? data_ovr :
                   (m_busy ? mem_word(m_addr) : $urandom);
      #1;
      e_stall = m_busy || m_q.size() == DEPTH || flush_i;
      e_pc    = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
      e_inst  = (m_q.size() != 0) ? m_q[0][31:0]  : 32'h0;
      if (id_valid_o && id_inst_o == 32'hDEADBEEF) seen_dead = 1;
      n_cmp++;
      if (rom_req_o !== m_busy) begin
         n_bad++;
         $display("FAIL rom_req t=%0t got %b want %b", $time, rom_req_o, m_busy);
      end
      n_cmp++;
      if (rom_addr_o !== m_addr) begin
         n_bad++;
         $display("FAIL rom_addr t=%0t got %h want %h", $time, rom_addr_o, m_addr);
      end
      n_cmp++;
      if (id_valid_o !== (m_q.size() != 0)) begin
         n_bad++;
         $display("FAIL id_valid t=%0t got %b want %b", $time, id_valid_o,
                  m_q.size() != 0);
      end
      n_cmp++;
      if (id_pc_o !== e_pc) begin
         n_bad++;
         $display("FAIL id_pc t=%0t got %h want %h", $time, id_pc_o, e_pc);
      end
      n_cmp++;
      if (id_inst_o !== e_inst) begin
         n_bad++;
         $display("FAIL id_inst t=%0t got %h want %h", $time, id_inst_o, e_inst);
      end
      n_cmp++;
      if (stall_req_o !== e_stall) begin
         n_bad++;
         $display("FAIL stall t=%0t got %b want %b", $time, stall_req_o, e_stall);
      end
      @(posedge clk);
      pop  = (m_q.size() != 0) && id_ready_i;
      push = 0;
      if (!m_busy) begin
         if (ce_i && !flush_i && m_q.size() < DEPTH) begin
            m_busy = 1;
            m_drop = 0;
            m_addr = pc_i;
            m_wait = (lat_max == 0) ? 0 : int'($urandom_range(lat_max, 0));
         end
      end else if (rom_ack_i) begin
         push   = !flush_i && !m_drop;
         m_busy = 0;
      end else begin
         if (flush_i) m_drop = 1;
         if (m_wait > 0) m_wait--;
      end
      if (flush_i) begin
         m_q.delete();
      end else begin
         if (pop)  void'(m_q.pop_front());
         if (push) m_q.push_back({m_addr, rom_data_i});
      end
      @(negedge clk);
      if (auto_pc && ce_i && !e_stall) pc_i = pc_i + 32'd4;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (rom_req_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_req got %b want 0", rom_req_o);
      end
      n_cmp++;
      if (rom_addr_o !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_addr got %h want 0", rom_addr_o);
      end
      n_cmp++;
      if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_id got %b/%h/%h want 0/0/0", id_valid_o, id_pc_o,
                  id_inst_o);
      end
      m_q.delete();
      m_busy = 0;
      m_drop = 0;
      m_addr = '0;
      m_wait = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic settle();
      ce_i = 1'b0;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      for (int i = 0; i < 10 && m_busy; i++) step();
   endtask

   task automatic test_reset();
      @(negedge clk);
      do_reset();
      step();
      step();
   endtask

   task automatic test_stream();
      ce_i = 1'b1;
      pc_i = 32'h0;
      id_ready_i = 1'b1;
      auto_pc = 1;
      lat_max = 0;
      do_reset();
      for (int i = 0; i < 16; i++) step();
   endtask

   task automatic test_full();
      id_ready_i = 1'b0;
      ce_i = 1'b1;
      for (int i = 0; i < 12; i++) step();
      n_cmp++;
      if (stall_req_o !== 1'b1 || rom_req_o !== 1'b0) begin
         n_bad++;
         $display("FAIL full_hold got stall=%b req=%b want 1/0", stall_req_o,
                  rom_req_o);
      end
      id_ready_i = 1'b1;
      step();
      id_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) step();
   endtask

   task automatic test_flush_wait();
      auto_pc = 0;
      id_ready_i = 1'b1;
      settle();
      ce_i = 1'b1;
      pc_i = 32'h200;
      ack_en = 0;
      step();
      flush_i = 1'b1;
      pc_i = 32'h100;
      step();
      flush_i = 1'b0;
      step();
      step();
      seen_dead = 0;
      ack_en = 1;
      use_ovr = 1;
      data_ovr = 32'hDEADBEEF;
      step();
      use_ovr = 0;
      step();
      n_cmp++;
      if (rom_addr_o !== 32'h100 || rom_req_o !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_newpc got req=%b addr=%h want 1/00000100",
                  rom_req_o, rom_addr_o);
      end
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if (seen_dead !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_drop got seen=%b want 0", seen_dead);
      end
   endtask

   task automatic test_flush_ack();
      id_ready_i = 1'b0;
      settle();
      ce_i = 1'b1;
      pc_i = 32'h300;
      auto_pc = 1;
      for (int i = 0; i < 10 && m_q.size() < 2; i++) step();
      ack_en = 0;
      step();
      flush_i = 1'b1;
      ack_en = 1;
      step();
      flush_i = 1'b0;
      ce_i = 1'b0;
      auto_pc = 0;
      step();
      n_cmp++;
      if (id_valid_o !== 1'b0 || rom_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_ack got valid=%b req=%b stall=%b want 0/0/0",
                  id_valid_o, rom_req_o, stall_req_o);
      end
   endtask

   task automatic test_reset_midfetch();
      ce_i = 1'b1;
      pc_i = 32'h400;
      ack_en = 0;
      step();
      step();
      do_reset();
      ce_i = 1'b0;
      ack_en = 1;
      stray = 1;
      for (int i = 0; i < 4; i++) step();
      stray = 0;
      n_cmp++;
      if (id_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL stray_ack got valid=%b want 0", id_valid_o);
      end
   endtask

   task automatic test_ce_drain();
      id_ready_i = 1'b0;
      settle();
      ce_i = 1'b1;
      pc_i = 32'h500;
      auto_pc = 1;
      for (int i = 0; i < 12 && (m_q.size() + int'(m_busy)) < 3; i++) step();
      ce_i = 1'b0;
      for (int i = 0; i < 10 && m_busy; i++) step();
      id_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      n_cmp++;
      if (id_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL drain got valid=%b want 0", id_valid_o);
      end
      for (int i = 0; i < 3; i++) step();
      n_cmp++;
      if (id_valid_o !== 1'b0 || rom_req_o !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_idle got valid=%b req=%b want 0/0", id_valid_o,
                  rom_req_o);
      end
   endtask

   task automatic test_random();
      lat_max = 3;
      auto_pc = 1;
      for (int i = 0; i < 800; i++) begin
         ce_i = ($urandom_range(7, 0) != 0);
         id_ready_i = ($urandom_range(2, 0) != 0);
         flush_i = ($urandom_range(19, 0) == 0);
         stray = ($urandom_range(5, 0) == 0);
         if (flush_i) pc_i = $urandom & 32'hFFFF_FFFC;
         step();
      end
      flush_i = 1'b0;
      stray = 0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_flush_wait();
      test_flush_ack();
      test_reset_midfetch();
      test_ce_drain();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Sits between the PC register / instruction ROM and the IF/ID stage.
- Takes the current PC and chip enable, and issues one request at a time to instruction memory using a req/ack handshake with variable latency.
- Buffers returned {pc, inst} pairs in a small FIFO, which decode drains through a valid/ready handshake.
- Provides flush for branches and exceptions, and a stall request back to the PC stage.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH), used for the FIFO pointers.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high (RstEnable).
- pc_i  in  32  fetch address from the PC stage.
- ce_i  in  1  PC stage chip enable; ChipEnable means pc_i is valid.
- flush_i  in  1  discard all buffered and in-flight fetches.
- rom_req_o  out  1  memory request; held high until ack.
- rom_addr_o  out  32  registered request address.
- rom_ack_i  in  1  memory response strobe, one cycle.
- rom_data_i  in  32  instruction word; valid with rom_ack_i.
- id_valid_o  out  1  FIFO head valid.
- id_pc_o  out  32  PC of the head entry.
- id_inst_o  out  32  instruction of the head entry.
- id_ready_i  in  1  decode accepts the head this cycle.
- stall_req_o  out  1  the PC stage must hold pc_i this cycle.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, count=0, both pointers=0.
  - rom_req_o=0, rom_addr_o=ZeroWord.
  - id_valid_o=0.
- Empty-FIFO outputs: while count==0, id_pc_o and id_inst_o read ZeroWord.
- State machine IDLE / WAIT / DROP, encodings in defines.v:
  - IDLE: if ce_i==ChipEnable && !flush_i && count<DEPTH, then:
    - latch rom_addr_o<=pc_i and rom_req_o<=1;
    - go to WAIT.
    - Otherwise stay in IDLE with rom_req_o=0.
  - WAIT: rom_req_o=1 and rom_addr_o is stable.
    - rom_ack_i && !flush_i: push {rom_addr_o, rom_data_i}, set rom_req_o<=0, go to IDLE.
    - flush_i && !rom_ack_i: go to DROP; rom_req_o stays 1, because the request cannot be withdrawn.
    - flush_i && rom_ack_i in the same cycle: discard the data, set rom_req_o<=0, go to IDLE.
  - DROP: on rom_ack_i, discard the data, set rom_req_o<=0, go to IDLE. Further flushes have no extra effect.
- Memory timing:
  - rom_ack_i is sampled only in WAIT or DROP; it is ignored in IDLE.
  - Minimum latency is request-to-ack 1 cycle, so a fetch takes at least 2 cycles from issue to push.
- stall_req_o is combinational: high when state!=IDLE, or count==DEPTH, or flush_i.
- Fetch-to-FIFO latency: an entry pushed at edge N is visible on id_* after edge N. There is no bypass from rom_data_i.
- FIFO space:
  - A request is issued only when count<DEPTH.
  - At most one request is in flight, so every accepted ack has a free slot.
- Pop: fires when id_valid_o && id_ready_i. id_ready_i is ignored when the FIFO is empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Flush:
  - Synchronous: count, rd_ptr and wr_ptr all go to 0 at the edge.
  - Flush overrides a simultaneous push and pop.
  - id_valid_o=0 from the next cycle onward.
- ce_i low: no new requests are issued, the FIFO continues to drain, and any in-flight fetch completes normally.
- Reset mid-fetch: the block returns to IDLE, and any late ack is ignored.
- Addresses are passed through unchanged; alignment checking belongs to a later stage.

Decomposition:
- Add to defines.v:
  - InstAddrBus and InstBus widths;
  - RstEnable, ChipEnable, ZeroWord;
  - FetchIdle, FetchWait, FetchDrop (2-bit state encodings).
- Sub-module fetch_fifo:
  - Parameters: DEPTH and width 64.
  - Signals: push, pop, clear, full, empty, count, head data.
  - Same asynchronous reset as the parent.
- The parent holds the FSM, the request register and the stall logic.

Test Plan:
1. Reset release, ce_i=1, pc_i=0x0, memory acks 1 cycle after req, id_ready_i=1:
   - rom_req_o rises the first cycle after reset.
   - id_valid_o first goes high with id_pc_o=0x0 and id_inst_o=mem[0].
   - Subsequent PCs 0x4 and 0x8 appear in order.
2. id_ready_i=0, 4 acks:
   - count=4 and stall_req_o=1.
   - No 5th rom_req_o.
   - After one pop, exactly one new request issues.
3. Flush while in WAIT, ack 3 cycles later with data 0xDEADBEEF:
   - The data is never presented.
   - id_valid_o=0.
   - The next request uses the new pc_i=0x100.
4. flush_i and rom_ack_i in the same cycle, with FIFO holding 2 entries:
   - The FIFO is empty next cycle.
   - The acked word is discarded.
   - State is IDLE.
5. Assert rst in WAIT, then issue a stray ack after release:
   - Outputs are zero immediately on reset.
   - The stray ack is ignored and count stays 0.
6. ce_i=0 with 3 entries and id_ready_i=1:
   - 3 entries drain over 3 cycles.
   - No rom_req_o.
   - id_valid_o then stays 0.
